request_unit: RTL and testbench
===============================

Name: request_unit

Overview:
Sequences instruction-fetch and data-memory requests for the single-cycle datapath. It is the consumer of the memory and halt controls produced by the instruction decoder (memREN, memWEN, halt), and the initiator towards the cache/memory side (imemREN, dmemREN, dmemWEN, qualified by ihit/dhit). It gates PC update and holds data requests until they are acknowledged. Sits between control decode, PC register and the cache interface.

Parameters:
MAX_WAIT, 64, max cycles a data request may stay unacknowledged before the error trap; legal range 1..65535.
CNT_W, 32, width of the performance counters. Used only when REQ_PERF_CNT_EN is defined.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous, active-high reset.
memREN_i  in  1  decoded load. Valid in the cycle ihit=1.
memWEN_i  in  1  decoded store. Valid in the cycle ihit=1.
halt_i  in  1  decoded HALT. Valid in the cycle ihit=1.
ihit  in  1  instruction fetch acknowledge.
dhit  in  1  data access acknowledge.
imemREN  out  1  instruction fetch request.
dmemREN  out  1  data read request.
dmemWEN  out  1  data write request.
pc_en  out  1  PC advance strobe, one cycle per retired instruction.
halted  out  1  sticky halt indication.
req_err  out  1  sticky error: timeout, or REN and WEN both set.
instr_cnt  out  CNT_W  retired-instruction count.
stall_cnt  out  CNT_W  cycles spent in DATA.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high.
- State register: reqstate_t, with states FETCH, DATA and HALTED. Reset state is FETCH.
- While RST=1, all outputs are 0. req_err, the wait counter, the latched request bits and both perf counters clear to 0.
- FETCH:
  - imemREN=1; dmem outputs are 0.
  - On ihit with memREN_i|memWEN_i: latch the request bits, pc_en=0, next state DATA.
  - On ihit with halt_i (and no mem op): pc_en=0, next state HALTED.
  - On ihit otherwise: pc_en=1 in the same cycle, stay in FETCH. A non-memory instruction therefore takes 1 cycle when ihit is immediate.
  - Without ihit: pc_en=0, stay in FETCH.
  - dhit is ignored in FETCH.
- DATA:
  - imemREN=0. dmemREN and dmemWEN are driven from the latched bits, held stable until dhit.
  - On dhit: pc_en=1 in the same cycle, the wait counter clears, next state FETCH.
  - ihit is ignored in DATA.
  - The wait counter ($clog2(MAX_WAIT+1) bits) increments each DATA cycle without dhit.
  - If the counter equals MAX_WAIT and dhit=0: set req_err, drop requests, next state HALTED.
- Simultaneous memREN_i and memWEN_i at ihit: WEN wins (a store is issued, REN is latched as 0) and req_err is set. Operation otherwise continues.
- Priority: mem op is executed before halt_i if both are decoded. HALTED is entered only after the data access completes with dhit.
- HALTED: halted=1, all request outputs and pc_en are 0. The state is left only by RST.
- Reset mid-request: the request drops in the reset cycle and no pc_en is issued. After reset the unit resumes from FETCH.
- Memory-op latency: ihit cycle + N DATA cycles, where N ≥ 1 counts up to and including the dhit cycle.

Optional Feature:
REQ_PERF_CNT_EN.
- Defined:
  - instr_cnt increments on each pc_en.
  - stall_cnt increments on each DATA-state cycle.
  - Both wrap modulo 2^CNT_W and freeze in HALTED.
- Undefined: the counter logic is absent and both ports are tied to 0. The port list is unchanged.

Decomposition:
- cpu_types_pkg gains:
  - typedef enum reqstate_t {FETCH, DATA, HALTED};
  - localparam REQ_WAIT_DEFAULT = 64.
- One sub-module, req_timer: a parameterised saturating wait counter with clear/enable inputs and an expired output, reused later by the cache FSMs.

Test Plan:
- Reset, then ihit=1 with all decode inputs 0 for 3 cycles -> pc_en=1 on each of those cycles; imemREN=1; dmem outputs 0.
- Load: ihit with memREN_i=1, dhit delayed 3 cycles -> dmemREN=1 for 3 cycles; imemREN=0; pc_en=1 only in the dhit cycle; back to FETCH; stall_cnt=3 with REQ_PERF_CNT_EN.
- Store with dhit never asserted, MAX_WAIT=4 -> dmemWEN=1 for 4 cycles, then req_err=1, halted=1, all requests 0.
- ihit with memREN_i=1 and memWEN_i=1 -> dmemWEN=1, dmemREN=0, req_err=1; completes normally on dhit.
- ihit with halt_i=1 -> halted=1 next cycle and stays 1; further ihit/dhit pulses produce no pc_en.
- RST asserted in the 2nd DATA cycle of a load -> outputs 0 that cycle; next cycle FETCH with imemREN=1; req_err=0; counters 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: request sequencer states and defaults
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FETCH,
        DATA,
        HALTED
    } reqstate_t;

    localparam int REQ_WAIT_DEFAULT = 64;

endpackage

// File: rtl/req_timer.sv
// rtl/req_timer.sv - saturating wait counter with clear/enable and an expired flag
module req_timer #(
    parameter int MAX = 64,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && (r_count != MAX_V)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == MAX_V);

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - fetch/data request sequencer; REQ_PERF_CNT_EN adds perf counters
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int MAX_WAIT = REQ_WAIT_DEFAULT,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             memREN_i,
    input  logic             memWEN_i,
    input  logic             halt_i,
    input  logic             ihit,
    input  logic             dhit,
    output logic             imemREN,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic             pc_en,
    output logic             halted,
    output logic             req_err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    reqstate_t r_state;
    logic      r_ren;
    logic      r_wen;
    logic      r_halt;
    logic      r_req_err;

    logic w_in_fetch;
    logic w_in_data;
    logic w_mem_op;
    logic w_expired;
    logic w_pc_en;

    assign w_in_fetch = (r_state == FETCH);
    assign w_in_data  = (r_state == DATA);
    assign w_mem_op   = memREN_i | memWEN_i;

    req_timer #(
        .MAX(MAX_WAIT)
    ) u_wait (
        .clk    (CLK),
        .rst    (RST),
        .clr    (~w_in_data | dhit),
        .en     (w_in_data & ~dhit),
        .expired(w_expired)
    );

    assign w_pc_en = ~RST & ((w_in_fetch & ihit & ~w_mem_op & ~halt_i) |
                             (w_in_data & dhit));

    // Requests drop in the cycle the wait budget is exhausted.
    assign imemREN = ~RST & w_in_fetch;
    assign dmemREN = ~RST & w_in_data & r_ren & ~w_expired;
    assign dmemWEN = ~RST & w_in_data & r_wen & ~w_expired;
    assign pc_en   = w_pc_en;
    assign halted  = ~RST & (r_state == HALTED);
    assign req_err = ~RST & r_req_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= FETCH;
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
            r_halt    <= 1'b0;
            r_req_err <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (ihit && w_mem_op) begin
                        r_wen   <= memWEN_i;
                        r_ren   <= memREN_i & ~memWEN_i;
                        r_halt  <= halt_i;
                        r_state <= DATA;
                        if (memREN_i && memWEN_i) begin
                            r_req_err <= 1'b1;
                        end
                    end else if (ihit && halt_i) begin
                        r_state <= HALTED;
                    end
                end
                DATA: begin
                    if (dhit) begin
                        r_ren   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_state <= r_halt ? HALTED : FETCH;
                    end else if (w_expired) begin
                        r_ren     <= 1'b0;
                        r_wen     <= 1'b0;
                        r_req_err <= 1'b1;
                        r_state   <= HALTED;
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= FETCH;
            endcase
        end
    end

`ifdef REQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_instr_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pc_en) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
            if (w_in_data) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign instr_cnt = RST ? '0 : r_instr_cnt;
    assign stall_cnt = RST ? '0 : r_stall_cnt;
`else
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - scoreboard bench for request_unit (MAX_WAIT=4)
module tb_request_unit;

`ifdef REQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        memREN_i, memWEN_i, halt_i, ihit, dhit;
    logic        imemREN, dmemREN, dmemWEN, pc_en, halted, req_err;
    logic [31:0] instr_cnt, stall_cnt;

    int checks   = 0;
    int failures = 0;

    logic [5:0] sb_q[$];

    request_unit #(.MAX_WAIT(4), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .memREN_i(memREN_i), .memWEN_i(memWEN_i), .halt_i(halt_i),
        .ihit(ihit), .dhit(dhit),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .pc_en(pc_en), .halted(halted), .req_err(req_err),
        .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // row = {RST,memREN_i,memWEN_i,halt_i,ihit,dhit, imem,dren,dwen,pc_en,halted,req_err}
    task automatic apply_row(input logic [11:0] row);
        logic [5:0] stim;
        stim = row[11:6];
        {RST, memREN_i, memWEN_i, halt_i, ihit, dhit} = stim;
        sb_q.push_back(row[5:0]);
    endtask

    task automatic do_reset();
        {RST, memREN_i, memWEN_i, halt_i, ihit, dhit} = 6'b100000;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] rows [2] = '{12'b110010_000000, 12'b101110_000000};
        logic [5:0]  exp, obs;
        for (int i = 0; i < 2; i++) begin
            apply_row(rows[i]);
            @(negedge CLK);
            obs = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
            checks++;
            if (sb_q.size() == 0) begin
                failures++; $display("FAIL reset[%0d] scoreboard empty", i);
            end else begin
                exp = sb_q.pop_front();
                if (obs !== exp) begin
                    failures++; $display("FAIL reset[%0d] got=%b want=%b", i, obs, exp);
                end
            end
            checks++;
            if (instr_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
                failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", instr_cnt, stall_cnt);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_nonmem();
        logic [11:0] rows [4] = '{12'b000010_100100, 12'b000010_100100,
                                  12'b000010_100100, 12'b000000_100000};
        logic [5:0]  exp, obs;
        logic [31:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_row(rows[i]);
            @(negedge CLK);
            obs = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
            checks++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 6'bxxxxxx;
            if (obs !== exp) begin
                failures++; $display("FAIL nonmem[%0d] got=%b want=%b", i, obs, exp);
            end
            @(posedge CLK); #1;
        end
        exp_cnt = PERF ? 32'd3 : 32'd0;
        checks++;
        if (instr_cnt !== exp_cnt) begin
            failures++; $display("FAIL nonmem_instr_cnt got=%0d want=%0d", instr_cnt, exp_cnt);
        end
    endtask

    task automatic test_load();
        logic [11:0] rows [5] = '{12'b010010_100000, 12'b000000_010000, 12'b000000_010000,
                                  12'b000001_010100, 12'b000000_100000};
        logic [5:0]  exp, obs;
        logic [31:0] exp_i, exp_s;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply_row(rows[i]);
            @(negedge CLK);
            obs = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
            checks++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 6'bxxxxxx;
            if (obs !== exp) begin
                failures++; $display("FAIL load[%0d] got=%b want=%b", i, obs, exp);
            end
            @(posedge CLK); #1;
        end
        exp_i = PERF ? 32'd1 : 32'd0;
        exp_s = PERF ? 32'd3 : 32'd0;
        checks++;
        if (instr_cnt !== exp_i || stall_cnt !== exp_s) begin
            failures++;
            $display("FAIL load_cnt got=%0d/%0d want=%0d/%0d", instr_cnt, stall_cnt, exp_i, exp_s);
        end
    endtask

    task automatic test_store_timeout();
        logic [11:0] rows [8] = '{12'b001010_100000, 12'b000000_001000, 12'b000000_001000,
                                  12'b000000_001000, 12'b000000_001000, 12'b000000_000000,
                                  12'b000000_000011, 12'b000011_000011};
        logic [5:0]  exp, obs;
        logic [31:0] exp_s;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply_row(rows[i]);
            @(negedge CLK);
            obs = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
            checks++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 6'bxxxxxx;
            if (obs !== exp) begin
                failures++; $display("FAIL timeout[%0d] got=%b want=%b", i, obs, exp);
            end
            @(posedge CLK); #1;
        end
        exp_s = PERF ? 32'd5 : 32'd0;
        checks++;
        if (stall_cnt !== exp_s || instr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL timeout_cnt got=%0d/%0d want=0/%0d", instr_cnt, stall_cnt, exp_s);
        end
    endtask

    task automatic test_both();
        logic [11:0] rows [4] = '{12'b011010_100000, 12'b000000_001001,
                                  12'b000001_001101, 12'b000000_100001};
        logic [5:0]  exp, obs;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_row(rows[i]);
            @(negedge CLK);
            obs = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
            checks++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 6'bxxxxxx;
            if (obs !== exp) begin
                failures++; $display("FAIL both[%0d] got=%b want=%b", i, obs, exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_halt();
        logic [11:0] rows [4] = '{12'b000110_100000, 12'b000010_000010,
                                  12'b000001_000010, 12'b000011_000010};
        logic [11:0] prio [3] = '{12'b010110_100000, 12'b000001_010100, 12'b000010_000010};
        logic [5:0]  exp, obs;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_row(rows[i]);
            @(negedge CLK);
            obs = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
            checks++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 6'bxxxxxx;
            if (obs !== exp) begin
                failures++; $display("FAIL halt[%0d] got=%b want=%b", i, obs, exp);
            end
            @(posedge CLK); #1;
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply_row(prio[i]);
            @(negedge CLK);
            obs = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
            checks++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 6'bxxxxxx;
            if (obs !== exp) begin
                failures++; $display("FAIL halt_prio[%0d] got=%b want=%b", i, obs, exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] rows [4] = '{12'b010010_100000, 12'b000000_010000,
                                  12'b110000_000000, 12'b000000_100000};
        logic [5:0]  exp, obs;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply_row(rows[i]);
            @(negedge CLK);
            obs = {imemREN, dmemREN, dmemWEN, pc_en, halted, req_err};
            checks++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 6'bxxxxxx;
            if (obs !== exp) begin
                failures++; $display("FAIL reset_mid[%0d] got=%b want=%b", i, obs, exp);
            end
            if (i == 3) begin
                checks++;
                if (instr_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
                    failures++;
                    $display("FAIL reset_mid_cnt got=%0d/%0d want=0/0", instr_cnt, stall_cnt);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        {RST, memREN_i, memWEN_i, halt_i, ihit, dhit} = 6'b100000;
        @(posedge CLK); #1;
        test_reset();
        test_nonmem();
        test_load();
        test_store_timeout();
        test_both();
        test_halt();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
